flag_register: RTL and testbench

FLAG_REGISTER -- requirements
Module: flag_register

---
 rtl/alu_pkg.sv | 29 ++
 rtl/cond_eval.sv | 28 ++
 rtl/flag_register.sv | 89 ++++++++
 tb/tb_flag_register.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU constants, condition-code enum and flag layout used by the
// flag register and its condition evaluator.
package alu_pkg;

   localparam int WIDTH_DEF = 32;

   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;

   typedef enum logic [2:0] {
      EQ = 3'b000,
      NE = 3'b001,
      LT = 3'b010,
      GE = 3'b011,
      CS = 3'b100,
      CC = 3'b101,
      VS = 3'b110,
      AL = 3'b111
   } cond_e;

   // Packed so that the bit order matches the {N,Z,C,V} output vector.
   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } flags_t;

endpackage

// File: rtl/cond_eval.sv
// Combinational condition-code decoder over a {N,Z,C,V} flag vector.
module cond_eval
   import alu_pkg::*;
(
   input  logic [3:0] flags,
   input  logic [2:0] cond,
   output logic       true
);

   flags_t f;
   assign f = flags;

   always_comb begin
      true = 1'b0;
      case (cond_e'(cond))
         EQ:      true = f.z;
         NE:      true = ~f.z;
         LT:      true = f.n ^ f.v;
         GE:      true = ~(f.n ^ f.v);
         CS:      true = f.c;
         CC:      true = ~f.c;
         VS:      true = f.v;
         AL:      true = 1'b1;
         default: true = 1'b0;
      endcase
   end

endmodule

// File: rtl/flag_register.sv
// ALU status-flag register with forwarded condition evaluation and a
// sticky, saturating overflow event counter.
module flag_register
   import alu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_in,
   input  logic [2:0]       op_sel,
   input  logic             msb_a,
   input  logic             msb_b,
   input  logic [WIDTH-1:0] result,
   input  logic             carry_in,
   input  logic             stall,
   input  logic             flush,
   input  logic             cond_req,
   input  logic [2:0]       cond,
   input  logic             clr_sticky,
   output logic [3:0]       flags_q,
   output logic             cond_valid,
   output logic             cond_true,
   output logic             ovf_sticky,
   output logic [CNT_W-1:0] ovf_count
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   flags_t flags_r;
   flags_t flags_nxt;
   logic   upd_acc;
   logic   req_acc;
   logic   is_arith;
   logic   v_new;
   logic   ovf_hit;
   logic   true_nxt;

   assign upd_acc  = valid_in & ~stall & ~flush;
   assign req_acc  = cond_req & ~stall & ~flush;
   assign is_arith = (op_sel == OP_ADD) || (op_sel == OP_SUB);

   // Operands agree in effective sign (B inverted for sub) but result sign differs.
   assign v_new   = is_arith & ~(msb_a ^ op_sel[0] ^ msb_b) & (msb_a ^ result[WIDTH-1]);
   assign ovf_hit = upd_acc & v_new;

   always_comb begin
      flags_nxt = flags_r;
      if (upd_acc) begin
         flags_nxt.n = result[WIDTH-1];
         flags_nxt.z = (result == '0);
         flags_nxt.c = is_arith ? carry_in : flags_r.c;
         flags_nxt.v = v_new;
      end
   end

   // Evaluating on flags_nxt forwards a same-cycle update into the condition.
   cond_eval u_cond_eval (
      .flags (flags_nxt),
      .cond  (cond),
      .true  (true_nxt)
   );

   // NOTE: rst is tested inside the clocked block, making it synchronous.
   always_ff @(posedge clk) begin
      if (rst) begin
         flags_r    <= '0;
         cond_valid <= 1'b0;
         cond_true  <= 1'b0;
         ovf_sticky <= 1'b0;
         ovf_count  <= '0;
      end else begin
         flags_r    <= flags_nxt;
         cond_valid <= req_acc;
         cond_true  <= req_acc & true_nxt;
         if (clr_sticky) begin
            ovf_sticky <= ovf_hit;
            ovf_count  <= ovf_hit ? CNT_W'(1) : '0;
         end else if (ovf_hit) begin
            ovf_sticky <= 1'b1;
            if (ovf_count != CNT_MAX) ovf_count <= ovf_count + CNT_W'(1);
         end
      end
   end

   assign flags_q = flags_r;

endmodule

// File: tb/tb_flag_register.sv
// Directed self-checking bench for flag_register with hand-computed expectations.
module tb_flag_register;
   import alu_pkg::*;

   localparam int WIDTH = 32;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             valid_in;
   logic [2:0]       op_sel;
   logic             msb_a;
   logic             msb_b;
   logic [WIDTH-1:0] result;
   logic             carry_in;
   logic             stall;
   logic             flush;
   logic             cond_req;
   logic [2:0]       cond;
   logic             clr_sticky;
   logic [3:0]       flags_q;
   logic             cond_valid;
   logic             cond_true;
   logic             ovf_sticky;
   logic [CNT_W-1:0] ovf_count;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   flag_register #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .valid_in   (valid_in),
      .op_sel     (op_sel),
      .msb_a      (msb_a),
      .msb_b      (msb_b),
      .result     (result),
      .carry_in   (carry_in),
      .stall      (stall),
      .flush      (flush),
      .cond_req   (cond_req),
      .cond       (cond),
      .clr_sticky (clr_sticky),
      .flags_q    (flags_q),
      .cond_valid (cond_valid),
      .cond_true  (cond_true),
      .ovf_sticky (ovf_sticky),
      .ovf_count  (ovf_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one edge and settle away from it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      valid_in   = 1'b0;
      op_sel     = 3'b000;
      msb_a      = 1'b0;
      msb_b      = 1'b0;
      result     = '0;
      carry_in   = 1'b0;
      stall      = 1'b0;
      flush      = 1'b0;
      cond_req   = 1'b0;
      cond       = 3'b000;
      clr_sticky = 1'b0;
   endtask

   task automatic alu(input logic [2:0] op, input logic a, input logic b,
                      input logic [WIDTH-1:0] res, input logic cy);
      valid_in = 1'b1;
      op_sel   = op;
      msb_a    = a;
      msb_b    = b;
      result   = res;
      carry_in = cy;
   endtask

   task automatic req(input cond_e c);
      cond_req = 1'b1;
      cond     = c;
   endtask

   initial begin
      idle();
      rst = 1'b1;
      step();
      step();
      check("rst_flags", flags_q, 4'b0000);
      check("rst_cvalid", cond_valid, 1'b0);
      check("rst_ctrue", cond_true, 1'b0);
      check("rst_sticky", ovf_sticky, 1'b0);
      check("rst_count", ovf_count, 0);

      rst = 1'b0;
      step();
      check("idle_flags", flags_q, 4'b0000);

      // Overflowing add: 0x7.. + 0x0.. -> 0x80000000
      alu(OP_ADD, 1'b0, 1'b0, 32'h8000_0000, 1'b0);
      step();
      idle();
      check("add_ovf_flags", flags_q, 4'b1001);
      check("add_ovf_sticky", ovf_sticky, 1'b1);
      check("add_ovf_count", ovf_count, 1);
      check("add_ovf_cvalid", cond_valid, 1'b0);

      // Sub 5-5 with same-cycle EQ request sees the forwarded Z
      alu(OP_SUB, 1'b0, 1'b0, 32'h0, 1'b1);
      req(EQ);
      step();
      idle();
      check("sub_flags", flags_q, 4'b0110);
      check("sub_cvalid", cond_valid, 1'b1);
      check("sub_ctrue", cond_true, 1'b1);
      check("sub_count", ovf_count, 1);
      step();
      check("strobe_cvalid", cond_valid, 1'b0);
      check("strobe_ctrue", cond_true, 1'b0);

      // Non-arithmetic op holds C, clears V
      alu(3'b000, 1'b0, 1'b0, 32'h0, 1'b0);
      req(CS);
      step();
      idle();
      check("logic_flags", flags_q, 4'b0110);
      check("logic_cs", cond_true, 1'b1);

      alu(3'b111, 1'b1, 1'b1, 32'hFFFF_0000, 1'b0);
      req(LT);
      step();
      idle();
      check("logic_neg_flags", flags_q, 4'b1010);
      check("logic_lt", cond_true, 1'b1);

      // Request alone on registered flags 1010: GE false
      req(GE);
      step();
      idle();
      check("ge_cvalid", cond_valid, 1'b1);
      check("ge_ctrue", cond_true, 1'b0);

      // Suppression: stall, stall+flush, flush
      alu(OP_ADD, 1'b0, 1'b0, 32'h8000_0000, 1'b1);
      req(AL);
      stall = 1'b1;
      step();
      check("stall_flags", flags_q, 4'b1010);
      check("stall_cvalid", cond_valid, 1'b0);
      check("stall_count", ovf_count, 1);
      flush = 1'b1;
      step();
      check("stflush_flags", flags_q, 4'b1010);
      check("stflush_cvalid", cond_valid, 1'b0);
      stall = 1'b0;
      step();
      idle();
      check("flush_flags", flags_q, 4'b1010);
      check("flush_cvalid", cond_valid, 1'b0);
      check("flush_count", ovf_count, 1);

      // Sub overflow: positive - negative = negative
      alu(OP_SUB, 1'b0, 1'b1, 32'h8000_0001, 1'b0);
      step();
      idle();
      check("sub_ovf_flags", flags_q, 4'b1001);
      check("sub_ovf_count", ovf_count, 2);

      // Add with mixed operand signs never overflows
      alu(OP_ADD, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
      step();
      idle();
      check("add_mixed_flags", flags_q, 4'b1000);
      check("add_mixed_count", ovf_count, 2);

      // Saturation
      alu(OP_ADD, 1'b0, 1'b0, 32'h8000_0000, 1'b0);
      for (int i = 0; i < 300; i++) step();
      check("sat_count", ovf_count, 255);
      check("sat_sticky", ovf_sticky, 1'b1);

      // Clear coinciding with overflow
      clr_sticky = 1'b1;
      step();
      check("clr_ovf_sticky", ovf_sticky, 1'b1);
      check("clr_ovf_count", ovf_count, 1);

      // Clear acts under stall; flushed overflow does not count
      valid_in = 1'b1;
      stall    = 1'b1;
      step();
      check("clr_stall_sticky", ovf_sticky, 1'b0);
      check("clr_stall_count", ovf_count, 0);
      stall = 1'b0;
      flush = 1'b1;
      step();
      check("clr_flush_count", ovf_count, 0);
      flush      = 1'b0;
      clr_sticky = 1'b0;
      step();
      check("post_clr_count", ovf_count, 1);

      // Reset mid-operation overrides an in-flight update and request
      alu(OP_ADD, 1'b0, 1'b0, 32'h8000_0000, 1'b1);
      req(AL);
      rst = 1'b1;
      step();
      check("rstmid_flags", flags_q, 4'b0000);
      check("rstmid_cvalid", cond_valid, 1'b0);
      check("rstmid_ctrue", cond_true, 1'b0);
      check("rstmid_sticky", ovf_sticky, 1'b0);
      check("rstmid_count", ovf_count, 0);
      idle();
      rst = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
